// File: rtl/fighter_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fighter_anim_ctrl
// Desc   : Fighter animation sequencer (stand/walk/punch/kick/hit-stun) and
//          mirrored sprite-ROM address generator.
// Rev    : 1.0  initial release
// ============================================================================
module fighter_anim_ctrl #(
  parameter int unsigned FRAME_W     = 64,
  parameter int unsigned FRAME_H     = 64,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned HOLD_FRAMES = 6
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic              vsync_tick,
  input  logic              punch_req,
  input  logic              kick_req,
  input  logic              walk,
  input  logic              hit,
  input  logic              facing_left,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_sprite,
  output logic [2:0]        anim_state,
  output logic              busy,
  output logic              attack_active
);

  typedef enum logic [2:0] {
    ST_STAND   = 3'd0,
    ST_WALK    = 3'd1,
    ST_PUNCH   = 3'd2,
    ST_KICK    = 3'd3,
    ST_HITSTUN = 3'd4
  } state_t;

  localparam int unsigned c_FRAME_SZ   = FRAME_W * FRAME_H;
  localparam logic [3:0]  c_HOLD_LAST  = 4'(HOLD_FRAMES - 1);
  localparam logic [3:0]  c_F_STAND    = 4'd0;
  localparam logic [3:0]  c_F_WALK_A   = 4'd1;
  localparam logic [3:0]  c_F_WALK_B   = 4'd2;
  localparam logic [3:0]  c_F_PUNCH_0  = 4'd3;
  localparam logic [3:0]  c_F_PUNCH_N  = 4'd5;
  localparam logic [3:0]  c_F_KICK_0   = 4'd6;
  localparam logic [3:0]  c_F_KICK_N   = 4'd9;
  localparam logic [3:0]  c_F_HIT      = 4'd10;

  state_t      r_state, w_state_n;
  logic [3:0]  r_frame, w_frame_n;
  logic [3:0]  r_hold, w_hold_n;
  logic        r_hs_step, w_hs_step_n;
  logic        r_pend_p, r_pend_k, r_pend_h;
  logic        w_pend_p_n, w_pend_k_n, w_pend_h_n;
  logic        r_busy, r_attack;
  logic        w_eff_p, w_eff_k, w_eff_h;
  logic        w_step_end, w_next_busy, w_drop_attacks, w_attack_n;

  // A request arriving on the tick cycle itself counts for that tick.
  assign w_eff_p    = r_pend_p | punch_req;
  assign w_eff_k    = r_pend_k | kick_req;
  assign w_eff_h    = r_pend_h | hit;
  assign w_step_end = (r_hold == c_HOLD_LAST);

  always_comb begin
    w_state_n   = r_state;
    w_frame_n   = r_frame;
    w_hold_n    = r_hold;
    w_hs_step_n = r_hs_step;
    if (vsync_tick) begin
      w_hold_n = w_step_end ? 4'd0 : r_hold + 4'd1;
      if (w_eff_h) begin
        w_state_n   = ST_HITSTUN;
        w_frame_n   = c_F_HIT;
        w_hold_n    = 4'd0;
        w_hs_step_n = 1'b0;
      end else begin
        unique case (r_state)
          ST_STAND, ST_WALK: begin
            if (w_eff_k) begin
              w_state_n = ST_KICK;
              w_frame_n = c_F_KICK_0;
              w_hold_n  = 4'd0;
            end else if (w_eff_p) begin
              w_state_n = ST_PUNCH;
              w_frame_n = c_F_PUNCH_0;
              w_hold_n  = 4'd0;
            end else if (!walk) begin
              w_frame_n = c_F_STAND;
              if (r_state == ST_WALK) begin
                w_state_n = ST_STAND;
                w_hold_n  = 4'd0;
              end
            end else if (r_state == ST_STAND) begin
              w_state_n = ST_WALK;
              w_frame_n = c_F_WALK_A;
              w_hold_n  = 4'd0;
            end else if (w_step_end) begin
              w_frame_n = (r_frame == c_F_WALK_A) ? c_F_WALK_B : c_F_WALK_A;
            end
          end
          ST_PUNCH, ST_KICK: begin
            // Punch and kick frame ranges are disjoint, so one last-frame test serves both.
            if (w_step_end) begin
              if (r_frame == c_F_PUNCH_N || r_frame == c_F_KICK_N) begin
                w_state_n = walk ? ST_WALK : ST_STAND;
                w_frame_n = walk ? c_F_WALK_A : c_F_STAND;
              end else begin
                w_frame_n = r_frame + 4'd1;
              end
            end
          end
          ST_HITSTUN: begin
            if (w_step_end) begin
              if (r_hs_step) begin
                w_state_n   = ST_STAND;
                w_frame_n   = c_F_STAND;
                w_hs_step_n = 1'b0;
              end else begin
                w_hs_step_n = 1'b1;
              end
            end
          end
          default: begin
            w_state_n   = ST_STAND;
            w_frame_n   = c_F_STAND;
            w_hold_n    = 4'd0;
            w_hs_step_n = 1'b0;
          end
        endcase
      end
    end
  end

  assign w_next_busy    = (w_state_n == ST_PUNCH) || (w_state_n == ST_KICK) ||
                          (w_state_n == ST_HITSTUN);
  assign w_drop_attacks = r_busy || (vsync_tick && w_next_busy);
  assign w_pend_p_n     = w_drop_attacks ? 1'b0 : w_eff_p;
  assign w_pend_k_n     = w_drop_attacks ? 1'b0 : w_eff_k;
  assign w_pend_h_n     = (vsync_tick && w_eff_h) ? 1'b0 : w_eff_h;
  assign w_attack_n     = (w_frame_n == 4'd4) || (w_frame_n == 4'd7) || (w_frame_n == 4'd8);

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_STAND;
      r_frame   <= c_F_STAND;
      r_hold    <= 4'd0;
      r_hs_step <= 1'b0;
      r_pend_p  <= 1'b0;
      r_pend_k  <= 1'b0;
      r_pend_h  <= 1'b0;
      r_busy    <= 1'b0;
      r_attack  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_frame   <= w_frame_n;
      r_hold    <= w_hold_n;
      r_hs_step <= w_hs_step_n;
      r_pend_p  <= w_pend_p_n;
      r_pend_k  <= w_pend_k_n;
      r_pend_h  <= w_pend_h_n;
      r_busy    <= w_next_busy;
      r_attack  <= w_attack_n;
    end
  end

  assign anim_state    = r_state;
  assign busy          = r_busy;
  assign attack_active = r_attack;

  // Pixel path: 11-bit differences keep DrawX<PosX from aliasing into the box.
  logic [10:0]       w_dx, w_dy, w_lx;
  logic              w_inside;
  logic [ADDR_W-1:0] w_addr;

  assign w_dx     = {1'b0, DrawX} - {1'b0, PosX};
  assign w_dy     = {1'b0, DrawY} - {1'b0, PosY};
  assign w_inside = (DrawX >= PosX) && (w_dx < 11'(FRAME_W)) &&
                    (DrawY >= PosY) && (w_dy < 11'(FRAME_H));
  assign w_lx     = facing_left ? (11'(FRAME_W - 1) - w_dx) : w_dx;
  assign w_addr   = ADDR_W'(32'(r_frame) * c_FRAME_SZ + 32'(w_dy) * FRAME_W + 32'(w_lx));

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      rom_address <= '0;
      in_sprite   <= 1'b0;
    end else begin
      rom_address <= w_inside ? w_addr : '0;
      in_sprite   <= w_inside;
    end
  end

endmodule
`default_nettype wire
